// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-port arbiter: port names, arbiter states,
// and the rotating first-set-bit search used for round-robin selection.
package noc_arb_pkg;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    localparam int HEADER_ID_DEF = 1;
    localparam int MAX_PORTS     = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    // First set bit of vec[n-1:0] at or after start (wrapping modulo n); -1 if none.
    // Walks downward so the closest position to start is the last one written.
    function automatic int rr_first(input logic [MAX_PORTS-1:0] vec, input int start, input int n);
        int idx;
        rr_first = -1;
        for (int k = MAX_PORTS - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = start + k;
                if (idx >= n) idx = idx - n;
                if (vec[idx]) rr_first = idx;
            end
        end
    endfunction

endpackage

// File: rtl/arb_timer.sv
// Per-port packet timer: latches the packet length on a header flit and counts
// cycles while its port holds the grant; timesup flags count == limit (limit 0 never expires).
module arb_timer #(
    parameter int LEN_W     = 12,
    parameter int FID_W     = 3,
    parameter int HEADER_ID = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FID_W-1:0] flit_id,
    input  logic [LEN_W-1:0] length,
    input  logic             run,
    output logic             timesup
);

    logic [LEN_W-1:0] limit;
    logic [LEN_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            limit <= '0;
            count <= '0;
        end else begin
            if (flit_id == FID_W'(HEADER_ID)) limit <= length;
            count <= run ? count + 1'b1 : '0;
        end
    end

    // A limit load in the same cycle only takes effect next cycle, so expiry sees the old limit.
    assign timesup = (limit != '0) && (count == limit);

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter: registered one-hot grant held while the winner
// requests and its packet timer has not expired; hand-over to the next requester has no idle gap.
module noc_rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NPORTS    = 5,
    parameter int LEN_W     = 12,
    parameter int FID_W     = 3,
    parameter int HEADER_ID = HEADER_ID_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS-1:0]         req,
    input  logic [NPORTS*FID_W-1:0]   flit_id,
    input  logic [NPORTS*LEN_W-1:0]   length,
    output logic [NPORTS-1:0]         grant,
    output logic                      grant_valid,
    output logic [$clog2(NPORTS)-1:0] grant_idx,
    output logic                      timeout
);

    localparam int IDX_W = $clog2(NPORTS);

    arb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [NPORTS-1:0]    timesup;
    logic [NPORTS-1:0]    run;
    logic                 keep;
    logic [MAX_PORTS-1:0] cand;
    logic [NPORTS-1:0]    next_grant;
    int                   start;
    int                   winner;

    always_comb begin
        keep  = (state == ST_HOLD) && req[grant_idx] && !timesup[grant_idx];
        cand  = '0;
        cand[NPORTS-1:0] = req;
        start = int'(ptr);
        // On release the current holder sits out one search and the scan begins just past it.
        if (state == ST_HOLD) begin
            cand[grant_idx] = 1'b0;
            start = (int'(grant_idx) + 1 == NPORTS) ? 0 : int'(grant_idx) + 1;
        end
        winner     = rr_first(cand, start, NPORTS);
        next_grant = '0;
        if (winner >= 0) next_grant[IDX_W'(winner)] = 1'b1;
        run = keep ? grant : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_timer
            arb_timer #(
                .LEN_W     (LEN_W),
                .FID_W     (FID_W),
                .HEADER_ID (HEADER_ID)
            ) u_timer (
                .clk     (clk),
                .rst     (rst),
                .flit_id (flit_id[gi*FID_W +: FID_W]),
                .length  (length[gi*LEN_W +: LEN_W]),
                .run     (run[gi]),
                .timesup (timesup[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
            ptr         <= '0;
        end else begin
            timeout <= 1'b0;
            if (!keep) begin
                if (state == ST_HOLD) timeout <= req[grant_idx] && timesup[grant_idx];
                if (winner >= 0) begin
                    state       <= ST_HOLD;
                    grant       <= next_grant;
                    grant_valid <= 1'b1;
                    grant_idx   <= IDX_W'(winner);
                    ptr         <= (winner + 1 == NPORTS) ? '0 : IDX_W'(winner + 1);
                end else begin
                    state       <= ST_IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    grant_idx   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Bench for noc_rr_arbiter: directed scenarios plus randomized traffic against
// an integer-level reference model of the arbitration and timer rules.
module tb_noc_rr_arbiter;
    import noc_arb_pkg::*;

    localparam int NP    = 5;
    localparam int LEN_W = 12;
    localparam int FID_W = 3;
    localparam int HDR   = 1;
    localparam int IW    = $clog2(NP);
    localparam int OW    = NP + 1 + IW + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NP-1:0]         req;
    logic [NP*FID_W-1:0]   flit_id;
    logic [NP*LEN_W-1:0]   length;
    logic [NP-1:0]         grant;
    logic                  grant_valid;
    logic [IW-1:0]         grant_idx;
    logic                  timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: holder = granted port or -1 when idle.
    int m_holder;
    int m_ptr;
    int m_cnt [NP];
    int m_lim [NP];
    bit m_to;

    noc_rr_arbiter #(
        .NPORTS    (NP),
        .LEN_W     (LEN_W),
        .FID_W     (FID_W),
        .HEADER_ID (HDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .flit_id     (flit_id),
        .length      (length),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic model_step();
        bit ts [NP];
        int h;
        int j;
        if (rst) begin
            m_holder = -1; m_ptr = 0; m_to = 1'b0;
            for (int i = 0; i < NP; i++) begin m_cnt[i] = 0; m_lim[i] = 0; end
            return;
        end
        for (int i = 0; i < NP; i++) ts[i] = (m_lim[i] != 0) && (m_cnt[i] == m_lim[i]);
        for (int i = 0; i < NP; i++)
            if (int'(flit_id[i*FID_W +: FID_W]) == HDR) m_lim[i] = int'(length[i*LEN_W +: LEN_W]);
        m_to = 1'b0;
        h = m_holder;
        if (h >= 0 && req[h] && !ts[h]) begin
            m_cnt[h] = (m_cnt[h] + 1) % (1 << LEN_W);
        end else begin
            if (h >= 0) begin
                m_to = req[h] && ts[h];
                m_cnt[h] = 0;
            end
            m_holder = -1;
            for (int k = 0; k < NP; k++) begin
                j = ((h >= 0 ? h + 1 : m_ptr) + k) % NP;
                if (j != h && req[j]) begin
                    m_holder = j;
                    m_ptr = (j + 1) % NP;
                    break;
                end
            end
        end
    endtask

    function automatic logic [OW-1:0] exp_out();
        logic [NP-1:0] g;
        logic [IW-1:0] ix;
        g = '0; ix = '0;
        if (m_holder >= 0) begin g[m_holder] = 1'b1; ix = IW'(m_holder); end
        return {g, (m_holder >= 0), ix, m_to};
    endfunction

    function automatic logic [OW-1:0] dut_out();
        return {grant, grant_valid, grant_idx, timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic set_hdr(input int port, input int len);
        flit_id[port*FID_W +: FID_W] = FID_W'(HDR);
        length[port*LEN_W +: LEN_W]  = LEN_W'(len);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; flit_id = '0; length = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (dut_out() !== OW'(0)) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, dut_out(), OW'(0));
            end
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++;
                $display("FAIL reset_model cyc=%0d got=%b want=%b", cyc, dut_out(), exp_out());
            end
        end
    endtask

    task automatic test_timeout_l();
        logic [NP-1:0] eg [11] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00001,
                                   5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00001};
        logic          et [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        set_hdr(PORT_L, 3);
        tick();
        flit_id = '0;
        req = 5'b00001;
        for (int c = 0; c < 11; c++) begin
            tick();
            checks++;
            if (grant !== eg[c] || timeout !== et[c]) begin
                errors++;
                $display("FAIL timeout_l step=%0d grant=%b timeout=%b want grant=%b timeout=%b",
                         c, grant, timeout, eg[c], et[c]);
            end
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++;
                $display("FAIL timeout_l_model cyc=%0d got=%b want=%b", cyc, dut_out(), exp_out());
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_rotation();
        logic [NP-1:0] rq [3] = '{5'b10110, 5'b10100, 5'b10000};
        logic [NP-1:0] eg [3] = '{5'b00010, 5'b00100, 5'b10000};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req = rq[c];
            tick();
            checks++;
            if (grant !== eg[c] || grant_idx !== IW'($clog2(int'(eg[c])))) begin
                errors++;
                $display("FAIL rotation step=%0d grant=%b idx=%0d want grant=%b", c, grant, grant_idx, eg[c]);
            end
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++;
                $display("FAIL rotation_model cyc=%0d got=%b want=%b", cyc, dut_out(), exp_out());
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_timeout_skip();
        int n;
        do_reset();
        set_hdr(PORT_W, 2);
        tick();
        flit_id = '0;
        req = 5'b01000;
        tick();
        req = 5'b01001;
        n = 0;
        do begin
            tick();
            n++;
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++;
                $display("FAIL skip_model cyc=%0d got=%b want=%b", cyc, dut_out(), exp_out());
            end
        end while (grant === 5'b01000 && n < 10);
        checks++;
        if (grant !== 5'b00001 || timeout !== 1'b1 || n != 3) begin
            errors++;
            $display("FAIL skip_to_l grant=%b timeout=%b after=%0d want grant=00001 timeout=1 after=3",
                     grant, timeout, n);
        end
        tick();
        checks++;
        if (grant !== 5'b00001 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL skip_pulse grant=%b timeout=%b want grant=00001 timeout=0", grant, timeout);
        end
        req = '0;
        tick();
    endtask

    task automatic test_no_timeout();
        int bad = 0;
        do_reset();
        set_hdr(PORT_E, 0);
        tick();
        flit_id = '0;
        req = 5'b00100;
        for (int c = 0; c < 5000; c++) begin
            tick();
            checks++;
            if (grant !== 5'b00100 || timeout !== 1'b0) begin
                errors++;
                if (bad++ < 5)
                    $display("FAIL no_timeout step=%0d grant=%b timeout=%b want grant=00100 timeout=0",
                             c, grant, timeout);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        set_hdr(PORT_N, 3);
        tick();
        flit_id = '0;
        req = 5'b00010;
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (grant !== 5'b00000 || timeout !== 1'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset grant=%b timeout=%b valid=%b want all zero", grant, timeout, grant_valid);
        end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (grant !== 5'b00010 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_hold step=%0d grant=%b timeout=%b want grant=00010 timeout=0",
                         c, grant, timeout);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        logic inv;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                flit_id[i*FID_W +: FID_W] = ($urandom_range(0, 3) == 0) ? FID_W'(HDR) : FID_W'($urandom_range(2, 7));
                length[i*LEN_W +: LEN_W]  = LEN_W'($urandom_range(0, 5));
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if (dut_out() !== exp_out()) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL random cyc=%0d got=%b want=%b", cyc, dut_out(), exp_out());
            end
            inv = $onehot0(grant) && (grant_valid === (|grant)) &&
                  ((grant == '0) ? (grant_idx == '0) : grant[grant_idx]);
            checks++;
            if (inv !== 1'b1) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL invariant cyc=%0d grant=%b valid=%b idx=%0d", cyc, grant, grant_valid, grant_idx);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; flit_id = '0; length = '0;
        m_holder = -1; m_ptr = 0; m_to = 1'b0;
        for (int i = 0; i < NP; i++) begin m_cnt[i] = 0; m_lim[i] = 0; end
        test_reset();
        test_timeout_l();
        test_rotation();
        test_timeout_skip();
        test_no_timeout();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_rr_arbiter.md
Name: noc_rr_arbiter

Overview:
- Parametrised round-robin output-port arbiter for the NoC router. Next generation of the fixed five-port L/N/E/W/S arbiter.
- Grants one of NPORTS input ports, one-hot and registered. Holds the grant while the winner keeps requesting, until its per-port packet timer expires.
- Each port has a timeout limit, loaded from the packet length field when a header flit arrives.
- Adds a rotating priority pointer, a no-timeout mode for length 0, and timeout status outputs.

Parameters:
- NPORTS, 5, number of requesting input ports; port 0=L, 1=N, 2=E, 3=W, 4=S when 5.
- LEN_W, 12, width of the length field and of the timer counter.
- FID_W, 3, width of the flit_id field.
- HEADER_ID, 1, flit_id value that identifies a header flit and loads the timer limit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  NPORTS  per-port request; bit i belongs to port i.
- flit_id  input  NPORTS*FID_W  per-port flit id; port i occupies slice [i*FID_W +: FID_W].
- length  input  NPORTS*LEN_W  per-port packet length in cycles; port i occupies slice [i*LEN_W +: LEN_W].
- grant  output  NPORTS  registered one-hot grant; all zero when idle.
- grant_valid  output  1  registered; high when grant is non-zero.
- grant_idx  output  $clog2(NPORTS)  registered index of the granted port; 0 when idle.
- timeout  output  1  registered one-cycle pulse, high in the cycle after a grant is released because its timer expired.

Behaviour:
- Reset (rst=1 at a clk edge):
  - grant=0, grant_valid=0, grant_idx=0, timeout=0.
  - Priority pointer ptr=0.
  - All timer counts=0, all timer limits=0.
- States: IDLE (grant=0) and HOLD(i) (grant[i]=1). Every output changes only on a clk edge; latency from a req change to a grant change is 1 cycle.
- IDLE:
  - Search req starting at port ptr, ascending modulo NPORTS.
  - First set bit j: next state HOLD(j), ptr<=(j+1) mod NPORTS.
  - No request: stay in IDLE.
- HOLD(i), keep condition: req[i]=1 and timesup[i]=0 -> stay in HOLD(i); timer i counts up.
- HOLD(i), release condition: req[i]=0 or timesup[i]=1.
  - Search starts at (i+1) mod NPORTS; port i is not eligible in this cycle.
  - First requester j: HOLD(j) directly, with no idle cycle; ptr<=(j+1) mod NPORTS.
  - No other requester: IDLE. Port i may be regranted from IDLE on the next cycle.
  - If the release was caused by timesup[i]=1 while req[i]=1, timeout is set to 1 for one cycle.
- Timer i, limit register:
  - When flit_id[i]==HEADER_ID, limit_i<=length[i] on the next edge.
  - Loading happens regardless of grant state. A load during HOLD(i) does not reset count_i.
- Timer i, counter:
  - Counts only while grant[i]=1 and the keep condition holds: count_i<=count_i+1.
  - Otherwise count_i<=0, so the count clears on release and stays 0 while not granted.
- timesup[i]:
  - Combinational: (limit_i!=0) and (count_i==limit_i).
  - limit_i=0 means no timeout; the grant is held until req[i] drops.
- Count width: LEN_W, no saturation. Wrap-around cannot occur because count_i is compared for equality with limit_i < 2^LEN_W. With limit 0 the count may wrap; that is harmless.
- Hold length: a granted port with limit L and continuous request holds grant for L+1 cycles (count 0..L). Release occurs on the edge after count reaches L.
- Simultaneous events:
  - A header load and timesup in the same cycle: timesup uses the old limit.
  - A req rising on several ports in IDLE: lowest index at or above ptr wins.
- Reset asserted mid-HOLD: the next edge forces IDLE and clears all timers; no timeout pulse is generated.
- Invariant: grant is always zero or one-hot; grant_valid==|grant; grant_idx matches grant.

Decomposition:
- Shared package noc_arb_pkg:
  - Port index constants PORT_L=0, PORT_N=1, PORT_E=2, PORT_W=3, PORT_S=4.
  - HEADER_ID default.
  - A function for the rotating first-set-bit search (input: vector plus start index).
- Sub-module arb_timer (clk, rst, flit_id, length, run, timesup) with parameters LEN_W, FID_W, HEADER_ID; instantiated NPORTS times in a generate loop.
- Top level holds the state/grant register, ptr, timeout, and the search logic.

Test Plan:
- Reset, then req=5'b00000 for 4 cycles -> grant=0, grant_valid=0, grant_idx=0, timeout=0 throughout.
- Header on L with length=3, then req=5'b00001 held -> grant=5'b00001 from cycle 1 for 4 cycles. Then timeout=1 for one cycle, one IDLE cycle, then regrant L with count restarted at 0.
- ptr=0, req=5'b10110 simultaneously from IDLE -> grant N(00010). Drop req[1] -> E(00100) next cycle with no idle gap. Drop req[2] -> S(10000).
- Holder W (limit 2) times out while req=5'b01001 -> next grant is L (00001), not W; timeout=1 pulse.
- Port E with limit 0 held for 5000 cycles with req[2]=1 -> grant stays 00100, timeout never asserts, even across count wrap.
- rst pulsed during HOLD(N) with count=2 -> next cycle grant=0, timeout=0. After reset release, a timer with no header reloaded has limit 0, so the port holds with no timeout.
